// File: rtl/bcd_display_scan.sv
// Four-digit seven-segment scanner: snapshots the BCD digits and sign once per
// frame and rotates through units/tens/hundreds/sign. Define BCD_SCAN_BLANK_EN for leading-zero blanking.
module bcd_display_scan #(
  parameter int PRESCALE = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] centena,
  input  logic [3:0] dezena,
  input  logic [3:0] unidade,
  input  logic       negative,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       frame
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);

`ifdef BCD_SCAN_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [3:0]    r_c;
  logic [3:0]    r_d;
  logic [3:0]    r_u;
  logic          r_neg;

  logic          w_step;
  logic          w_load;
  logic [1:0]    w_idx_next;
  logic [3:0]    w_c;
  logic [3:0]    w_d;
  logic [3:0]    w_u;
  logic          w_neg;
  logic [6:0]    w_seg_next;
  logic [3:0]    w_an_next;

  function automatic logic [6:0] f_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0000110;
    endcase
    return s;
  endfunction

  assign w_step     = (r_cnt == CNT_MAX);
  assign w_idx_next = r_idx + 2'd1;
  // The 3->0 step shows the fresh inputs immediately, so digit 0 bypasses the snapshot.
  assign w_load     = (r_idx == 2'd3);
  assign w_c        = w_load ? centena  : r_c;
  assign w_d        = w_load ? dezena   : r_d;
  assign w_u        = w_load ? unidade  : r_u;
  assign w_neg      = w_load ? negative : r_neg;
  assign w_an_next  = ~(4'b0001 << w_idx_next);

  always_comb begin
    w_seg_next = SEG_BLANK;
    case (w_idx_next)
      2'd0: w_seg_next = f_seg(w_u);
      2'd1: begin
        if (BLANK_EN && (w_c == 4'd0) && (w_d == 4'd0)) w_seg_next = SEG_BLANK;
        else                                            w_seg_next = f_seg(w_d);
      end
      2'd2: begin
        if (BLANK_EN && (w_c == 4'd0)) w_seg_next = SEG_BLANK;
        else                           w_seg_next = f_seg(w_c);
      end
      default: w_seg_next = w_neg ? SEG_MINUS : SEG_BLANK;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_idx <= 2'd3;
      r_c   <= 4'd0;
      r_d   <= 4'd0;
      r_u   <= 4'd0;
      r_neg <= 1'b0;
      an    <= 4'b1111;
      seg   <= SEG_BLANK;
      frame <= 1'b0;
    end else begin
      frame <= 1'b0;
      if (w_step) begin
        r_cnt <= '0;
        r_idx <= w_idx_next;
        an    <= w_an_next;
        seg   <= w_seg_next;
        if (w_load) begin
          r_c   <= centena;
          r_d   <= dezena;
          r_u   <= unidade;
          r_neg <= negative;
          frame <= 1'b1;
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Bench for bcd_display_scan: PRESCALE=4 and PRESCALE=1 instances checked every
// cycle against a frame/slot arithmetic model, plus a vector table and directed corner cases.
module tb_bcd_display_scan;

`ifdef BCD_SCAN_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  localparam int P0 = 4;
  localparam int P1 = 1;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] MI = 7'b0111111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] centena = 4'd0;
  logic [3:0] dezena = 4'd0;
  logic [3:0] unidade = 4'd0;
  logic       negative = 1'b0;
  logic [6:0] seg_a, seg_b;
  logic [3:0] an_a, an_b;
  logic       frame_a, frame_b;

  int checks = 0;
  int errors = 0;
  int n = 0;
  int pv[2];
  logic [3:0] s_c[2], s_d[2], s_u[2];
  logic       s_n[2];
  logic       fs[2];
  logic [6:0] code[16];

  typedef struct {
    logic [3:0] c, d, u;
    logic       neg;
    logic [6:0] e0, e1, e2, e3;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  bcd_display_scan #(.PRESCALE(P0)) dut_a (
    .clk(clk), .reset(reset), .centena(centena), .dezena(dezena),
    .unidade(unidade), .negative(negative),
    .seg(seg_a), .an(an_a), .frame(frame_a)
  );

  bcd_display_scan #(.PRESCALE(P1)) dut_b (
    .clk(clk), .reset(reset), .centena(centena), .dezena(dezena),
    .unidade(unidade), .negative(negative),
    .seg(seg_b), .an(an_b), .frame(frame_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] digit_seg(input int i, input int d);
    case (d)
      0: return code[s_u[i]];
      1: return (BLANK && s_c[i] == 0 && s_d[i] == 0) ? BL : code[s_d[i]];
      2: return (BLANK && s_c[i] == 0) ? BL : code[s_c[i]];
      default: return s_n[i] ? MI : BL;
    endcase
  endfunction

  // One clock: update the model at the edge, compare both instances at the falling edge.
  task automatic tick();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_fr;
    logic [11:0] act;
    @(posedge clk);
    n++;
    for (int i = 0; i < 2; i++) begin
      fs[i] = (n >= pv[i]) && (((n - pv[i]) % (4 * pv[i])) == 0);
      if (fs[i]) begin
        s_c[i] = centena; s_d[i] = dezena; s_u[i] = unidade; s_n[i] = negative;
      end
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (n < pv[i]) begin
        e_an = 4'b1111; e_seg = BL; e_fr = 1'b0;
      end else begin
        int d;
        d = ((n - pv[i]) / pv[i]) % 4;
        e_an = ~(4'b0001 << d);
        e_seg = digit_seg(i, d);
        e_fr = fs[i];
      end
      act = (i == 0) ? {an_a, seg_a, frame_a} : {an_b, seg_b, frame_b};
      check((i == 0) ? "cycle_p4" : "cycle_p1", {20'd0, act}, {20'd0, e_an, e_seg, e_fr});
    end
  endtask

  task automatic set_in(input logic [3:0] c, input logic [3:0] d, input logic [3:0] u, input logic ng);
    centena = c; dezena = d; unidade = u; negative = ng;
  endtask

  task automatic wait_frame();
    int k;
    k = 0;
    fs[0] = 1'b0;
    while (!fs[0] && k < 8 * P0) begin
      tick();
      k++;
    end
    if (!fs[0]) begin
      checks++; errors++;
      $display("FAIL frame_timeout: no frame within %0d cycles", 8 * P0);
    end
  endtask

  task automatic rand_nib(output logic [3:0] v);
    v = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rc, rd, ru;
    pv[0] = P0; pv[1] = P1;
    code[0] = 7'b1000000; code[1] = 7'b1111001; code[2] = 7'b0100100; code[3] = 7'b0110000;
    code[4] = 7'b0011001; code[5] = 7'b0010010; code[6] = 7'b0000010; code[7] = 7'b1111000;
    code[8] = 7'b0000000; code[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) code[i] = 7'b0000110;
    for (int i = 0; i < 2; i++) begin
      s_c[i] = 0; s_d[i] = 0; s_u[i] = 0; s_n[i] = 0; fs[i] = 0;
    end

    vecs[0] = '{4'd1, 4'd2, 4'd7, 1'b0, 7'b1111000, 7'b0100100, 7'b1111001, BL};
    vecs[1] = '{4'd0, 4'd0, 4'd5, 1'b1, 7'b0010010, BLANK ? BL : 7'b1000000, BLANK ? BL : 7'b1000000, MI};
    vecs[2] = '{4'd0, 4'd0, 4'd0, 1'b0, 7'b1000000, BLANK ? BL : 7'b1000000, BLANK ? BL : 7'b1000000, BL};
    vecs[3] = '{4'd0, 4'hC, 4'd3, 1'b0, 7'b0110000, 7'b0000110, BLANK ? BL : 7'b1000000, BL};
    vecs[4] = '{4'd9, 4'd0, 4'd8, 1'b1, 7'b0000000, 7'b1000000, 7'b0010000, MI};
    vecs[5] = '{4'hF, 4'd0, 4'd0, 1'b0, 7'b1000000, 7'b1000000, 7'b0000110, BL};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_a", {an_a, seg_a, frame_a}, {4'b1111, BL, 1'b0});
    check("reset_b", {an_b, seg_b, frame_b}, {4'b1111, BL, 1'b0});

    // First digit PRESCALE cycles after release
    set_in(4'd1, 4'd2, 4'd7, 1'b0);
    reset = 1'b0;
    n = 0;
    repeat (P0) tick();
    check("first_digit", {an_a, seg_a, frame_a}, {4'b1110, 7'b1111000, 1'b1});

    // Vector table
    for (int v = 0; v < 6; v++) begin
      set_in(vecs[v].c, vecs[v].d, vecs[v].u, vecs[v].neg);
      wait_frame();
      for (int k = 0; k < 4; k++) begin
        logic [6:0] e;
        e = (k == 0) ? vecs[v].e0 : (k == 1) ? vecs[v].e1 : (k == 2) ? vecs[v].e2 : vecs[v].e3;
        check($sformatf("vec%0d_digit%0d", v, k), {an_a, seg_a}, {~(4'b0001 << k), e});
        if (k < 3) repeat (P0) tick();
      end
    end

    // Inputs change mid-frame: current frame keeps the snapshot
    set_in(4'd1, 4'd2, 4'd7, 1'b0);
    wait_frame();
    repeat (P0) tick();
    check("midframe_tens_before", {an_a, seg_a}, {4'b1101, 7'b0100100});
    set_in(4'd3, 4'd4, 4'd5, 1'b0);
    repeat (P0) tick();
    check("midframe_hund_old", {an_a, seg_a}, {4'b1011, 7'b1111001});
    wait_frame();
    check("midframe_units_new", {an_a, seg_a}, {4'b1110, 7'b0010010});
    repeat (P0) tick();
    check("midframe_tens_new", {an_a, seg_a}, {4'b1101, 7'b0011001});
    repeat (P0) tick();
    check("midframe_hund_new", {an_a, seg_a}, {4'b1011, 7'b0110000});

    // Asynchronous reset mid-frame while the hundreds digit is lit
    #1 reset = 1'b1;
    #1;
    check("async_reset_a", {an_a, seg_a, frame_a}, {4'b1111, BL, 1'b0});
    check("async_reset_b", {an_b, seg_b, frame_b}, {4'b1111, BL, 1'b0});
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    repeat (P0 - 1) tick();
    check("post_reset_dark", {an_a, frame_a}, {4'b1111, 1'b0});
    tick();
    check("post_reset_first", {an_a, seg_a, frame_a}, {4'b1110, 7'b0010010, 1'b1});

    // Randomized inputs changing at arbitrary cycles
    repeat (600) begin
      if ($urandom_range(0, 5) == 0) begin
        rand_nib(rc); rand_nib(rd); rand_nib(ru);
        set_in(rc, rd, ru, 1'($urandom_range(0, 1)));
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
